// File: rtl/gcd_dp_pkg.sv
// Shared definitions for the binary-GCD datapath responder.
// Token indices are declared in execution-priority order: a lower index wins.
// tk_prio_sel() reduces a multi-hot token vector to the single token that runs.
package gcd_dp_pkg;

  localparam int GCD_DP_WIDTH_DEFAULT = 8;

  // The declaration order is the priority order: ldAB > fin > shAB > subA > subB > shA > shB.
  typedef enum logic [2:0] {
    TK_LD   = 3'd0,
    TK_FIN  = 3'd1,
    TK_SHAB = 3'd2,
    TK_SUBA = 3'd3,
    TK_SUBB = 3'd4,
    TK_SHA  = 3'd5,
    TK_SHB  = 3'd6
  } tk_e;

  localparam int NUM_TK = 7;

  // Keep only the lowest set bit, which is the highest-priority token.
  function automatic logic [NUM_TK-1:0] tk_prio_sel(input logic [NUM_TK-1:0] req);
    return req & (~req + NUM_TK'(1));
  endfunction

endpackage

// File: rtl/gcd_dp_operand_reg.sv
// One GCD operand register with load, logical shift-right and subtract.
// Ports: clk/rst (async active-high clear), ld+ld_val, shr, sub+sub_val (subtrahend), q.
// Commands are expected one-hot; if several are high, ld > sub > shr.
module gcd_dp_operand_reg #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ld,
  input  logic [WIDTH-1:0] ld_val,
  input  logic             shr,
  input  logic             sub,
  input  logic [WIDTH-1:0] sub_val,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] q_q;
  logic [WIDTH-1:0] q_d;

  always_comb begin
    q_d = q_q;
    if (ld) begin
      q_d = ld_val;
    end else if (sub) begin
      // Wrap-around is intentional; the controller only subtracts when there is no borrow.
      q_d = q_q - sub_val;
    end else if (shr) begin
      q_d = q_q >> 1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q_q <= '0;
    end else begin
      q_q <= q_d;
    end
  end

  assign q = q_q;

endmodule

// File: rtl/gcd_dp_responder.sv
// Datapath responder for a one-hot token GCD controller: executes one token per clock
// on A/B/k and returns status flags rzA, rzB, shDA, shDB, coA (combinational from A/B).
// Ports: clk, rst (async active-high), inA/inB, tokens ldAB fin shAB subA subB shA shB,
// status outputs, res with a one-cycle done pulse, and err.
// Build option GCD_DP_TOKEN_CHECK_EN: err becomes sticky on any multi-token cycle; else 0.
module gcd_dp_responder
  import gcd_dp_pkg::*;
#(
  parameter int WIDTH = GCD_DP_WIDTH_DEFAULT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] inA,
  input  logic [WIDTH-1:0] inB,
  input  logic             ldAB,
  input  logic             shAB,
  input  logic             shA,
  input  logic             shB,
  input  logic             subA,
  input  logic             subB,
  input  logic             fin,
  output logic             rzA,
  output logic             rzB,
  output logic             shDA,
  output logic             shDB,
  output logic             coA,
  output logic [WIDTH-1:0] res,
  output logic             done,
  output logic             err
);

  localparam int KW = $clog2(WIDTH + 1);

  logic [NUM_TK-1:0] tok;
  logic [NUM_TK-1:0] sel;
  logic [WIDTH-1:0]  a;
  logic [WIDTH-1:0]  b;

  assign tok[TK_LD]   = ldAB;
  assign tok[TK_FIN]  = fin;
  assign tok[TK_SHAB] = shAB;
  assign tok[TK_SUBA] = subA;
  assign tok[TK_SUBB] = subB;
  assign tok[TK_SHA]  = shA;
  assign tok[TK_SHB]  = shB;

  assign sel = tk_prio_sel(tok);

  gcd_dp_operand_reg #(.WIDTH(WIDTH)) u_opa (
    .clk     (clk),
    .rst     (rst),
    .ld      (sel[TK_LD]),
    .ld_val  (inA),
    .shr     (sel[TK_SHAB] | sel[TK_SHA]),
    .sub     (sel[TK_SUBA]),
    .sub_val (b),
    .q       (a)
  );

  gcd_dp_operand_reg #(.WIDTH(WIDTH)) u_opb (
    .clk     (clk),
    .rst     (rst),
    .ld      (sel[TK_LD]),
    .ld_val  (inB),
    .shr     (sel[TK_SHAB] | sel[TK_SHB]),
    .sub     (sel[TK_SUBB]),
    .sub_val (a),
    .q       (b)
  );

  // Status flags
  assign rzA  = (a == '0);
  assign rzB  = (b == '0);
  assign shDA = ~a[0];
  assign shDB = ~b[0];
  assign coA  = (a < b);

  // Common-shift counter, result and done
  logic [KW-1:0]    k_q, k_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic             done_q, done_d;
  logic [WIDTH-1:0] res_base;

  assign res_base = rzA ? b : a;

  always_comb begin
    k_d    = k_q;
    res_d  = res_q;
    done_d = sel[TK_FIN];
    if (sel[TK_LD]) begin
      k_d = '0;
    end else if (sel[TK_SHAB] && (k_q < KW'(WIDTH))) begin
      // Saturate at WIDTH: beyond that every result bit is shifted out anyway.
      k_d = k_q + KW'(1);
    end
    if (sel[TK_FIN]) begin
      res_d = res_base << k_q;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      k_q    <= '0;
      res_q  <= '0;
      done_q <= 1'b0;
    end else begin
      k_q    <= k_d;
      res_q  <= res_d;
      done_q <= done_d;
    end
  end

  assign res  = res_q;
  assign done = done_q;

`ifdef GCD_DP_TOKEN_CHECK_EN
  logic err_q, err_d;

  // More than one bit set: clearing the lowest set bit leaves something.
  always_comb begin
    err_d = err_q | ((tok & (tok - NUM_TK'(1))) != '0);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_q <= 1'b0;
    end else begin
      err_q <= err_d;
    end
  end

  assign err = err_q;
`else
  assign err = 1'b0;
`endif

endmodule

// File: tb/tb_gcd_dp_responder.sv
// Directed bench for gcd_dp_responder: hand-computed vectors, immediate-assertion checks.
module tb_gcd_dp_responder;
  import gcd_dp_pkg::*;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [W-1:0] inA = '0;
  logic [W-1:0] inB = '0;
  logic ldAB = 0, shAB = 0, shA = 0, shB = 0, subA = 0, subB = 0, fin = 0;
  logic rzA, rzB, shDA, shDB, coA, done, err;
  logic [W-1:0] res;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  gcd_dp_responder #(.WIDTH(W)) dut (
    .clk (clk), .rst (rst), .inA (inA), .inB (inB),
    .ldAB(ldAB), .shAB(shAB), .shA(shA), .shB(shB),
    .subA(subA), .subB(subB), .fin(fin),
    .rzA (rzA), .rzB (rzB), .shDA(shDA), .shDB(shDB), .coA(coA),
    .res (res), .done(done), .err(err)
  );

`ifdef GCD_DP_TOKEN_CHECK_EN
  localparam logic ERR_EXP = 1'b1;
`else
  localparam logic ERR_EXP = 1'b0;
`endif

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Flags packed as {rzA,rzB,shDA,shDB,coA}
  task automatic check_flags(input string tag, input logic [4:0] exp);
    check(tag, {27'd0, rzA, rzB, shDA, shDB, coA}, {27'd0, exp});
  endtask

  // Drive a token vector (bit index = tk_e) for one clock, then sample 1 time unit after the edge.
  task automatic step(input logic [NUM_TK-1:0] t, input logic [W-1:0] a, input logic [W-1:0] b);
    inA  = a;
    inB  = b;
    ldAB = t[TK_LD];
    fin  = t[TK_FIN];
    shAB = t[TK_SHAB];
    subA = t[TK_SUBA];
    subB = t[TK_SUBB];
    shA  = t[TK_SHA];
    shB  = t[TK_SHB];
    @(posedge clk);
    #1;
    {ldAB, fin, shAB, subA, subB, shA, shB} = '0;
  endtask

  function automatic logic [NUM_TK-1:0] tk(input tk_e t);
    logic [NUM_TK-1:0] v;
    v    = '0;
    v[t] = 1'b1;
    return v;
  endfunction

  initial begin
    // Reset, then idle.
    #13;
    rst = 1'b0;
    step('0, 0, 0);
    step('0, 0, 0);
    check_flags("reset_flags", 5'b11110);
    check("reset_res", {24'd0, res}, 32'd0);
    check("reset_done", {31'd0, done}, 32'd0);
    check("reset_err", {31'd0, err}, 32'd0);

    // GCD(12,18)
    step(tk(TK_LD), 12, 18);
    check_flags("ld_12_18_flags", 5'b00111);
    step(tk(TK_SHAB), 0, 0);
    check("shab_a", {24'd0, dut.a}, 32'd6);
    check("shab_b", {24'd0, dut.b}, 32'd9);
    check("shab_k", {28'd0, dut.k_q}, 32'd1);
    check_flags("shab_flags", 5'b00101);
    step(tk(TK_SUBB), 0, 0);
    check("subb_b", {24'd0, dut.b}, 32'd3);
    check_flags("subb_flags", 5'b00100);
    step(tk(TK_SHA), 0, 0);
    check("sha_a", {24'd0, dut.a}, 32'd3);
    step(tk(TK_SUBA), 0, 0);
    check_flags("suba_flags", 5'b10101);
    step(tk(TK_FIN), 0, 0);
    check("gcd12_18_res", {24'd0, res}, 32'd6);
    check("gcd12_18_done", {31'd0, done}, 32'd1);
    step('0, 0, 0);
    check("gcd12_18_done_low", {31'd0, done}, 32'd0);
    check("gcd12_18_res_hold", {24'd0, res}, 32'd6);

    // k saturation with both operands zero
    step(tk(TK_LD), 0, 0);
    for (int i = 0; i < 10; i++) step(tk(TK_SHAB), 0, 0);
    check("k_sat", {28'd0, dut.k_q}, 32'd8);
    step(tk(TK_FIN), 0, 0);
    check("zero_res", {24'd0, res}, 32'd0);
    check("zero_done", {31'd0, done}, 32'd1);

    // Multi-token: shA + shB, shA wins
    step(tk(TK_LD), 8, 4);
    check("multi_pre_err", {31'd0, err}, 32'd0);
    step(tk(TK_SHA) | tk(TK_SHB), 0, 0);
    check("multi_a", {24'd0, dut.a}, 32'd4);
    check("multi_b", {24'd0, dut.b}, 32'd4);
    check("multi_err", {31'd0, err}, {31'd0, ERR_EXP});
    step('0, 0, 0);
    check("multi_err_sticky", {31'd0, err}, {31'd0, ERR_EXP});

    // fin beats shAB: A=5 B=0 k=0 -> res=5, k holds
    step(tk(TK_LD), 5, 0);
    step(tk(TK_FIN) | tk(TK_SHAB), 0, 0);
    check("fin_prio_res", {24'd0, res}, 32'd5);
    check("fin_prio_k", {28'd0, dut.k_q}, 32'd0);

    // Asynchronous reset mid-operation
    step(tk(TK_LD), 12, 18);
    step(tk(TK_SHAB), 0, 0);
    #3 rst = 1'b1;
    #1;
    check("arst_a", {24'd0, dut.a}, 32'd0);
    check("arst_b", {24'd0, dut.b}, 32'd0);
    check("arst_k", {28'd0, dut.k_q}, 32'd0);
    check_flags("arst_flags", 5'b11110);
    check("arst_res", {24'd0, res}, 32'd0);
    check("arst_err", {31'd0, err}, 32'd0);
    #2 rst = 1'b0;
    step(tk(TK_LD), 7, 7);
    step(tk(TK_FIN), 0, 0);
    check("gcd7_7_res", {24'd0, res}, 32'd7);

    // ldAB after fin: res holds; back-to-back fin gives two pulses
    step(tk(TK_LD), 5, 0);
    check("ld_after_fin_res", {24'd0, res}, 32'd7);
    check("ld_after_fin_done", {31'd0, done}, 32'd0);
    step(tk(TK_FIN), 0, 0);
    check("b2b_fin1_res", {24'd0, res}, 32'd5);
    check("b2b_fin1_done", {31'd0, done}, 32'd1);
    step(tk(TK_FIN), 0, 0);
    check("b2b_fin2_done", {31'd0, done}, 32'd1);
    step('0, 0, 0);
    check("b2b_done_low", {31'd0, done}, 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
